// File: rtl/stair_pkg.sv
// Shared encodings and helpers for the staircase sequence counter.
package stair_pkg;

    // Run-order encoding used on the mode input and the latched mode.
    localparam logic MODE_ASC  = 1'b0;
    localparam logic MODE_DESC = 1'b1;

    // A programmed limit of zero behaves as a limit of one.
    function automatic logic [31:0] eff_lim(input logic [31:0] lim_in);
        return (lim_in == 32'd0) ? 32'd1 : lim_in;
    endfunction

endpackage

// File: rtl/stair_run_map.sv
// Maps a position within a run to the emitted element, ascending or descending.
module stair_run_map
    import stair_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_pos,
    input  logic [WIDTH-1:0] i_run,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_count
);

    // Descending runs count down from the run length: r, r-1, ..., 1.
    always_comb begin
        o_count = i_pos;
        if (i_mode == MODE_DESC)
            o_count = i_run - i_pos + WIDTH'(1);
    end

endmodule

// File: rtl/stair_seq_counter.sv
// Staircase sequence counter: runs of length 1..lim, each run 1..r or r..1.
module stair_seq_counter
    import stair_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] run,
    output logic             run_end,
    output logic             seq_end
);

    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] r_run;
    logic [WIDTH-1:0] r_lim;
    logic             r_mode;
    logic [WIDTH-1:0] w_eff_lim;
    logic             w_run_end;

    assign w_eff_lim = WIDTH'(eff_lim(32'(lim)));
    assign w_run_end = (r_pos == r_run);

    // Sequence state; mode is only picked up at a run start, limit only at a wrap or restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos  <= WIDTH'(1);
            r_run  <= WIDTH'(1);
            r_mode <= MODE_ASC;
            r_lim  <= '1;
        end else if (clr) begin
            r_pos  <= WIDTH'(1);
            r_run  <= WIDTH'(1);
            r_mode <= mode;
            r_lim  <= w_eff_lim;
        end else if (en) begin
            if (!w_run_end) begin
                r_pos <= r_pos + WIDTH'(1);
            end else begin
                r_pos  <= WIDTH'(1);
                r_mode <= mode;
                if (r_run < r_lim) begin
                    r_run <= r_run + WIDTH'(1);
                end else begin
                    r_run <= WIDTH'(1);
                    r_lim <= w_eff_lim;
                end
            end
        end
    end

    stair_run_map #(.WIDTH(WIDTH)) u_map (
        .i_pos   (r_pos),
        .i_run   (r_run),
        .i_mode  (r_mode),
        .o_count (count)
    );

    assign run     = r_run;
    assign run_end = w_run_end;
    assign seq_end = w_run_end & (r_run == r_lim);

endmodule

// File: tb/tb_stair_seq_counter.sv
// Directed bench for stair_seq_counter with an expected-value scoreboard queue.
module tb_stair_seq_counter;

    localparam int W = 3;

    typedef struct {
        logic [W-1:0] count;
        logic [W-1:0] run;
        logic         re;
        logic         se;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, en, clr, mode;
    logic [W-1:0] lim;
    logic [W-1:0] count, run;
    logic         run_end, seq_end;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    stair_seq_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .lim(lim),
        .count(count), .run(run), .run_end(run_end), .seq_end(seq_end)
    );

    always #5 clk = ~clk;

    // Element idx of a sequence with limit L, counted from the first element;
    // runs numbered >= desc_from are emitted in descending order.
    function automatic exp_t gen(input int L, input int desc_from, input int idx);
        exp_t e;
        int per = L * (L + 1) / 2;
        int i = idx % per;
        int r = 1;
        int p;
        while (i >= r) begin
            i -= r;
            r++;
        end
        p = i + 1;
        e.count = W'((r >= desc_from) ? (r - p + 1) : p);
        e.run   = W'(r);
        e.re    = (p == r);
        e.se    = (p == r) && (r == L);
        return e;
    endfunction

    function automatic exp_t mk(input int c, input int r, input logic re, input logic se);
        exp_t e;
        e.count = W'(c);
        e.run   = W'(r);
        e.re    = re;
        e.se    = se;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare all outputs against it.
    task automatic check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty-queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".count"},   32'(count),   32'(e.count));
            chk({tag, ".run"},     32'(run),     32'(e.run));
            chk({tag, ".run_end"}, 32'(run_end), 32'(e.re));
            chk({tag, ".seq_end"}, 32'(seq_end), 32'(e.se));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Restart with the current mode/lim; the first element shows after the edge.
    task automatic restart(input int L, input int desc_from, input string tag);
        clr = 1'b1;
        en  = 1'b0;
        exp_q.push_back(gen(L, desc_from, 0));
        step(tag);
        clr = 1'b0;
    endtask

    initial begin
        int idx;
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0; lim = 3'd7;

        // Reset values without any clock edge.
        #2;
        exp_q.push_back(mk(1, 1, 1'b1, 1'b0));
        check("reset");
        #1 rst = 1'b0;

        // First enabled edge after reset goes to run 2 (full limit latched).
        en = 1'b1;
        exp_q.push_back(mk(1, 2, 1'b0, 1'b0));
        step("first_en");

        // Ascending sweep, lim=7: 30 enabled cycles crosses the wrap at 28.
        mode = 1'b0; lim = 3'd7;
        restart(7, 99, "asc_clr");
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back(gen(7, 99, k));
            step($sformatf("asc[%0d]", k));
        end

        // Descending runs, lim=4, including the wrap back to 1.
        mode = 1'b1; lim = 3'd4;
        restart(4, 1, "desc_clr");
        en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            exp_q.push_back(gen(4, 1, k));
            step($sformatf("desc[%0d]", k));
        end

        // Enable gaps through run 3: state holds on en=0 cycles.
        mode = 1'b0; lim = 3'd7;
        restart(7, 99, "gap_clr");
        idx = 0;
        for (int k = 0; k < 14; k++) begin
            en = (k < 3) ? 1'b1 : ((k % 2) == 0);
            if (en) idx++;
            exp_q.push_back(gen(7, 99, idx));
            step($sformatf("gap[%0d]", k));
        end

        // Mode flipped mid run 3: run 3 stays ascending, run 4 on descends.
        mode = 1'b0; lim = 3'd7;
        restart(7, 4, "mode_clr");
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) mode = 1'b1;
            exp_q.push_back(gen(7, 4, k));
            step($sformatf("mode[%0d]", k));
        end

        // Limit lowered mid-sequence: current sequence finishes at 7, next uses 3.
        mode = 1'b0; lim = 3'd7;
        restart(7, 99, "lim_clr");
        en = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            if (k == 11) lim = 3'd3;
            exp_q.push_back(gen(7, 99, k));
            step($sformatf("lim7[%0d]", k));
        end
        for (int k = 0; k <= 6; k++) begin
            exp_q.push_back(gen(3, 99, k));
            step($sformatf("lim3[%0d]", k));
        end

        // lim=0 acts as 1: constant 1 with both end flags.
        lim = 3'd0;
        restart(1, 99, "lim0_clr");
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(gen(1, 99, k));
            step($sformatf("lim0[%0d]", k));
        end

        // Asynchronous reset in the middle of run 5.
        lim = 3'd7;
        restart(7, 99, "rst_clr");
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(gen(7, 99, k));
            step($sformatf("pre_rst[%0d]", k));
        end
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk(1, 1, 1'b1, 1'b0));
        check("async_rst");
        #3 rst = 1'b0;

        en = 1'b1;
        exp_q.push_back(mk(1, 2, 1'b0, 1'b0));
        step("post_rst_en");

        // clr and en together: restart wins.
        clr = 1'b1;
        exp_q.push_back(gen(7, 99, 0));
        step("clr_en");
        clr = 1'b0;
        exp_q.push_back(gen(7, 99, 1));
        step("after_clr_en");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
